// File: rtl/branch_unit_pkg.sv
// Shared branch-unit definitions: BHT counter states, branch funct3 encodings
// and the 2-bit saturating counter update.
package branch_unit_pkg;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    localparam logic [1:0] BHT_RESET = WNT;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    function automatic logic [1:0] bht_next(input logic [1:0] cnt, input logic taken);
        if (taken) return (cnt == ST)  ? ST  : cnt + 2'd1;
        else       return (cnt == SNT) ? SNT : cnt - 2'd1;
    endfunction

endpackage

// File: rtl/branch_unit_cond_eval.sv
// Combinational RV32I branch condition evaluator; taken is 0 for illegal funct3.
module br_cond_eval
    import branch_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            taken,
    output logic            legal
);

    always_comb begin
        taken = 1'b0;
        legal = 1'b1;
        case (funct3)
            F3_BEQ:  taken = (a == b);
            F3_BNE:  taken = (a != b);
            F3_BLT:  taken = ($signed(a) <  $signed(b));
            F3_BGE:  taken = ($signed(a) >= $signed(b));
            F3_BLTU: taken = (a <  b);
            F3_BGEU: taken = (a >= b);
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_unit.sv
// EX-stage branch resolution with a PC-indexed 2-bit BHT for IF prediction
// and branch / misprediction performance counters.
module branch_unit
    import branch_unit_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      if_pc,
    output logic             if_pred_taken,
    input  logic             ex_is_branch,
    input  logic [2:0]       ex_funct3,
    input  logic [XLEN-1:0]  ex_a,
    input  logic [XLEN-1:0]  ex_b,
    input  logic [31:0]      ex_pc,
    input  logic             ex_pred_taken,
    input  logic             ex_stall,
    output logic             ex_taken,
    output logic             ex_mispredict,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mispred_count
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    logic [BHT_ENTRIES-1:0][1:0] bht;
    logic [IDX_W-1:0]            if_idx;
    logic [IDX_W-1:0]            ex_idx;
    logic                        cond_taken;
    logic                        cond_legal;
    logic                        resolve;
    logic                        unused_pc_bits;

    br_cond_eval #(.XLEN(XLEN)) u_cond (
        .funct3 (ex_funct3),
        .a      (ex_a),
        .b      (ex_b),
        .taken  (cond_taken),
        .legal  (cond_legal)
    );

    // Word-aligned PCs: bits [1:0] and anything above the index never select an entry.
    assign if_idx = if_pc[IDX_W+1:2];
    assign ex_idx = ex_pc[IDX_W+1:2];
    assign unused_pc_bits = ^{if_pc[31:IDX_W+2], if_pc[1:0], ex_pc[31:IDX_W+2], ex_pc[1:0]};

    assign ex_taken      = ex_is_branch & cond_legal & cond_taken;
    assign resolve       = ex_is_branch & cond_legal & ~ex_stall;
    assign ex_mispredict = resolve & (ex_taken != ex_pred_taken);

    // No bypass: a same-cycle update to if_idx shows up one cycle later.
    assign if_pred_taken = bht[if_idx][1];

    always_ff @(posedge clk) begin
        if (rst) begin
            bht           <= {BHT_ENTRIES{BHT_RESET}};
            br_count      <= '0;
            mispred_count <= '0;
        end else if (resolve) begin
            bht[ex_idx] <= bht_next(bht[ex_idx], ex_taken);
            br_count    <= br_count + CNT_W'(1);
            if (ex_mispredict)
                mispred_count <= mispred_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_branch_unit.sv
// Directed self-checking bench for branch_unit.
module tb_branch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic        ex_is_branch;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_a, ex_b, ex_pc;
    logic        ex_pred_taken, ex_stall;
    logic        ex_taken, ex_mispredict;
    logic [31:0] br_count, mispred_count;

    int n_checks = 0;
    int n_pass   = 0;

    branch_unit #(.XLEN(32), .BHT_ENTRIES(64), .CNT_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .if_pc         (if_pc),
        .if_pred_taken (if_pred_taken),
        .ex_is_branch  (ex_is_branch),
        .ex_funct3     (ex_funct3),
        .ex_a          (ex_a),
        .ex_b          (ex_b),
        .ex_pc         (ex_pc),
        .ex_pred_taken (ex_pred_taken),
        .ex_stall      (ex_stall),
        .ex_taken      (ex_taken),
        .ex_mispredict (ex_mispredict),
        .br_count      (br_count),
        .mispred_count (mispred_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drive(input logic br, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] pc, input logic pred,
                         input logic stall);
        @(negedge clk);
        ex_is_branch  = br;
        ex_funct3     = f3;
        ex_a          = a;
        ex_b          = b;
        ex_pc         = pc;
        ex_pred_taken = pred;
        ex_stall      = stall;
        #1;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; if_pc = 32'h0;
        ex_is_branch = 1'b0; ex_funct3 = 3'b000; ex_a = '0; ex_b = '0;
        ex_pc = '0; ex_pred_taken = 1'b0; ex_stall = 1'b0;
        step; step;
        @(negedge clk); rst = 1'b0; #1;

        // Reset state
        if_pc = 32'h0000_0000; #1; chk("rst_pred_0", {31'b0, if_pred_taken}, 32'd0);
        if_pc = 32'h0000_00FC; #1; chk("rst_pred_fc", {31'b0, if_pred_taken}, 32'd0);
        if_pc = 32'h0000_0100; #1; chk("rst_pred_100", {31'b0, if_pred_taken}, 32'd0);
        chk("rst_br", br_count, 32'd0);
        chk("rst_mis", mispred_count, 32'd0);

        // Condition evaluation under stall (no state effects)
        drive(1, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h0, 0, 1); chk("blt_neg", {31'b0, ex_taken}, 32'd1);
        chk("blt_stall_mis", {31'b0, ex_mispredict}, 32'd0);
        drive(1, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h0, 0, 1); chk("bltu", {31'b0, ex_taken}, 32'd0);
        drive(1, 3'b101, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0, 0, 1); chk("bge_sgn", {31'b0, ex_taken}, 32'd0);
        drive(1, 3'b111, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0, 0, 1); chk("bgeu", {31'b0, ex_taken}, 32'd1);
        drive(1, 3'b001, 32'd5, 32'd5, 32'h0, 0, 1); chk("bne_eq", {31'b0, ex_taken}, 32'd0);
        drive(0, 3'b000, 32'd5, 32'd5, 32'h0, 0, 0); chk("not_branch", {31'b0, ex_taken}, 32'd0);
        step;
        chk("cond_br_idle", br_count, 32'd0);

        // Four taken BEQ at 0x40, predicted not-taken: 01->10->11->11
        if_pc = 32'h40;
        drive(1, 3'b000, 32'd5, 32'd5, 32'h40, 0, 0);
        chk("beq1_taken", {31'b0, ex_taken}, 32'd1);
        chk("beq1_mis", {31'b0, ex_mispredict}, 32'd1);
        chk("beq1_pred", {31'b0, if_pred_taken}, 32'd0);
        step; chk("beq2_pred", {31'b0, if_pred_taken}, 32'd1);
        step; chk("beq3_pred", {31'b0, if_pred_taken}, 32'd1);
        step; chk("beq4_pred", {31'b0, if_pred_taken}, 32'd1);
        step; chk("beq_sat_pred", {31'b0, if_pred_taken}, 32'd1);
        chk("beq_br", br_count, 32'd4);
        chk("beq_mis", mispred_count, 32'd4);

        // Two not-taken, predicted not-taken: 11->10->01 (proves saturation, not wrap)
        drive(1, 3'b000, 32'd5, 32'd6, 32'h40, 0, 0);
        chk("nt1_mis", {31'b0, ex_mispredict}, 32'd0);
        step; chk("nt1_pred", {31'b0, if_pred_taken}, 32'd1);
        step; chk("nt2_pred", {31'b0, if_pred_taken}, 32'd0);
        chk("nt_br", br_count, 32'd6);
        chk("nt_mis", mispred_count, 32'd4);

        // Same-cycle read/update collision at 0x80
        if_pc = 32'h80;
        drive(1, 3'b000, 32'd7, 32'd7, 32'h80, 0, 0);
        chk("coll_pred_same", {31'b0, if_pred_taken}, 32'd0);
        step;
        drive(0, 3'b000, 32'd0, 32'd0, 32'h0, 0, 0);
        chk("coll_pred_next", {31'b0, if_pred_taken}, 32'd1);
        chk("coll_br", br_count, 32'd7);
        chk("coll_mis", mispred_count, 32'd5);

        // Stalled taken branch at 0x40 (entry at 01): no state change
        if_pc = 32'h40;
        drive(1, 3'b000, 32'd9, 32'd9, 32'h40, 0, 1);
        chk("stall_taken", {31'b0, ex_taken}, 32'd1);
        chk("stall_mis", {31'b0, ex_mispredict}, 32'd0);
        step;
        chk("stall_pred", {31'b0, if_pred_taken}, 32'd0);
        chk("stall_br", br_count, 32'd7);
        chk("stall_miscnt", mispred_count, 32'd5);

        // Illegal funct3 010
        drive(1, 3'b010, 32'd9, 32'd9, 32'h40, 1, 0);
        chk("ill_taken", {31'b0, ex_taken}, 32'd0);
        chk("ill_mis", {31'b0, ex_mispredict}, 32'd0);
        step;
        chk("ill_br", br_count, 32'd7);
        chk("ill_pred", {31'b0, if_pred_taken}, 32'd0);

        // Reset concurrent with a valid taken resolve at 0x80 (entry at 10)
        if_pc = 32'h80;
        drive(1, 3'b000, 32'd3, 32'd3, 32'h80, 0, 0);
        rst = 1'b1;
        step;
        @(negedge clk); rst = 1'b0; ex_is_branch = 1'b0; #1;
        chk("rstc_pred80", {31'b0, if_pred_taken}, 32'd0);
        chk("rstc_br", br_count, 32'd0);
        chk("rstc_mis", mispred_count, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
